// File: rtl/dout_burst_writer.sv
// Burst write-back stage: buffers up to BURST result words, then
// issues one write command and drains the buffer on the data channel.
module dout_burst_writer #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int BURST   = 16,
    parameter int BL_BITS = 4,
    parameter int CNT_W   = 20
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               cfg_start,
    input  logic [AW-1:0]      cfg_addr_base,
    input  logic [AW-1:0]      cfg_addr_stride,
    input  logic [CNT_W-1:0]   cfg_word_num,
    output logic               busy,
    output logic               done,
    input  logic               s_vld,
    output logic               s_rdy,
    input  logic [DW-1:0]      s_data,
    output logic               m_cmd_vld,
    input  logic               m_cmd_rdy,
    output logic [AW-1:0]      m_cmd_addr,
    output logic [BL_BITS-1:0] m_cmd_len,
    output logic               m_wvld,
    input  logic               m_wrdy,
    output logic [DW-1:0]      m_wdata,
    output logic               m_wlast
);

    typedef enum logic [1:0] {IDLE, FILL, CMD, DATA} state_t;

    localparam logic [BL_BITS:0] FULL_M1 = (BL_BITS+1)'(BURST - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   remain;
    logic [AW-1:0]      addr, cmd_addr, stride;
    logic [BL_BITS:0]   wr_ptr, rd_ptr, wr_last;
    logic [DW-1:0]      wbuf [0:BURST-1];
    logic               done_q;
    logic               last_beat;

    assign wr_last   = wr_ptr - 1'b1;
    assign last_beat = (rd_ptr == wr_last);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (cfg_start && cfg_word_num != '0) state_n = FILL;
            FILL: begin
                if (s_vld && (wr_ptr == FULL_M1 || remain == CNT_W'(1)))
                    state_n = CMD;
            end
            CMD:  if (m_cmd_rdy) state_n = DATA;
            DATA: begin
                if (m_wrdy && last_beat)
                    state_n = (remain == '0) ? IDLE : FILL;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            remain   <= '0;
            addr     <= '0;
            cmd_addr <= '0;
            stride   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_start) begin
                        remain   <= cfg_word_num;
                        addr     <= cfg_addr_base;
                        cmd_addr <= cfg_addr_base;
                        stride   <= cfg_addr_stride;
                        wr_ptr   <= '0;
                        done_q   <= (cfg_word_num == '0);
                    end
                end
                FILL: begin
                    if (s_vld) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        remain <= remain - 1'b1;
                        addr   <= addr + stride;
                    end
                end
                CMD: if (m_cmd_rdy) rd_ptr <= '0;
                DATA: begin
                    if (m_wrdy) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        if (last_beat) begin
                            cmd_addr <= addr;
                            wr_ptr   <= '0;
                            done_q   <= (remain == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (state == FILL && s_vld)
            wbuf[wr_ptr[BL_BITS-1:0]] <= s_data;
    end

    always_comb begin
        s_rdy      = 1'b0;
        m_cmd_vld  = 1'b0;
        m_cmd_addr = '0;
        m_cmd_len  = '0;
        m_wvld     = 1'b0;
        m_wdata    = '0;
        m_wlast    = 1'b0;
        unique case (state)
            FILL: s_rdy = 1'b1;
            CMD: begin
                m_cmd_vld  = 1'b1;
                m_cmd_addr = cmd_addr;
                m_cmd_len  = wr_last[BL_BITS-1:0];
            end
            DATA: begin
                m_wvld  = 1'b1;
                m_wdata = wbuf[rd_ptr[BL_BITS-1:0]];
                m_wlast = last_beat;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = done_q;

endmodule

// File: doc/dout_burst_writer.md
# dout_burst_writer

Output write-back stage placed directly downstream of `dcnn_top`'s `dram_w_*` stream. It collects result words into a local buffer of `BURST` entries. For each buffer it issues one write command (address, length) on a memory command channel, then drains the buffered words on a memory data channel. Addresses start at a configured base and advance by a configured per-word stride. The block replaces the always-ready DRAM sink used during bring-up.

## Interface
Parameters:
- DW, 32, data word width
- AW, 32, address width
- BURST, 16, maximum words per burst; power of two, ≥2
- BL_BITS, 4, width of `m_cmd_len`; equals log2(BURST)
- CNT_W, 20, width of the total word counter

Ports:
- clk  in  1  single clock; all logic is rising-edge
- arst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse that starts a transfer; sampled only in IDLE
- cfg_addr_base  in  AW  byte address of the first word
- cfg_addr_stride  in  AW  byte increment per word
- cfg_word_num  in  CNT_W  total words to write
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when the transfer completes
- s_vld  in  1  input stream valid (from `dram_w_vld`)
- s_rdy  out  1  input stream ready (to `dram_w_rdy`)
- s_data  in  DW  input stream data
- m_cmd_vld  out  1  write command valid
- m_cmd_rdy  in  1  write command ready
- m_cmd_addr  out  AW  burst start byte address
- m_cmd_len  out  BL_BITS  words in the burst minus 1
- m_wvld  out  1  write data valid
- m_wrdy  in  1  write data ready
- m_wdata  out  DW  write data
- m_wlast  out  1  marks the final beat of a burst

## Operation
- States: IDLE, FILL, CMD, DATA.
- Registers:
  - `remain` (CNT_W): words not yet accepted.
  - `addr` (AW): byte address of the next word to be accepted.
  - `cmd_addr` (AW): start address of the current burst.
  - `wr_ptr` and `rd_ptr` (BL_BITS+1).
  - `buf[0:BURST-1]`.
- IDLE, on `cfg_start`:
  - Latch `remain=cfg_word_num`, `addr=cfg_addr_base`, `cmd_addr=cfg_addr_base`.
  - If `cfg_word_num==0`: pulse `done` next cycle, stay in IDLE, issue no command.
  - Otherwise go to FILL with `wr_ptr=0`.
- FILL:
  - `s_rdy=1`.
  - On each handshake (`s_vld&s_rdy`): `buf[wr_ptr]=s_data`, `wr_ptr++`, `remain--`, `addr+=cfg_addr_stride`.
  - Go to CMD on the handshake that makes `wr_ptr==BURST` or `remain==0`.
  - Stall indefinitely while `s_vld=0`; there is no timeout flush.
- CMD:
  - `m_cmd_vld=1`, `m_cmd_addr=cmd_addr`, `m_cmd_len=wr_ptr-1`. These values are held stable until `m_cmd_rdy`.
  - On the handshake: go to DATA with `rd_ptr=0`.
- DATA:
  - `m_wvld=1`, `m_wdata=buf[rd_ptr]`, `m_wlast=(rd_ptr==wr_ptr-1)`.
  - Each `m_wvld&m_wrdy` handshake increments `rd_ptr`.
  - On the `m_wlast` beat:
    - `cmd_addr=addr`, `wr_ptr=0`.
    - If `remain≠0`, go to FILL.
    - Otherwise go to IDLE and assert `done` for one cycle.
- Arithmetic: address addition wraps modulo 2^AW, with no error. `cfg_*` values are latched at start; later changes are ignored until the next start.
- `cfg_start` outside IDLE is ignored, with no effect on any counter.
- `s_rdy`, `m_cmd_vld` and `m_wvld` are never high in the same cycle, because each depends on its own state.

## Timing
- Reset (`arst_n=0`):
  - State becomes IDLE immediately and asynchronously.
  - All outputs are 0: `busy`, `done`, `s_rdy`, `m_cmd_vld`, `m_cmd_addr`, `m_cmd_len`, `m_wvld`, `m_wdata`, `m_wlast`.
  - Pointers and counters are cleared.
  - Buffer contents are don't-care.
- Reset mid-transfer: the partial burst is discarded and no `done` is produced. On release the block is in IDLE and accepts a new `cfg_start`.
- `cfg_start` at edge N:
  - `busy=1` and `s_rdy=1` from cycle N+1.
  - For `word_num==0`: `done=1` in cycle N+1 and `busy` stays 0.
- Last FILL handshake at edge M: `m_cmd_vld=1` in cycle M+1.
- Command handshake at edge C: `m_wvld=1` with word 0 in cycle C+1.
- Data-phase throughput is one word per cycle while `m_wrdy=1`.
- Last beat at edge L:
  - Cycle L+1 is either FILL (`s_rdy=1`) or IDLE with `done=1` and `busy=0`.
- All outputs are registered-state decodes or register reads; there is no combinational path from `s_vld`, `m_cmd_rdy` or `m_wrdy` to any output.

## Test plan
- Multi-burst transfer:
  - Stimulus: base=0x0000_FFFF, stride=4, word_num=40, data 1..40 with `s_vld` always high; ready signals always high.
  - Required: 3 commands, (0xFFFF, 15), (0x1_003F, 15), (0x1_007F, 7); data beats 1..40 in order; `m_wlast` on words 16, 32 and 40; exactly one `done`.
- Random backpressure:
  - Stimulus: word_num=20; `m_cmd_rdy`, `m_wrdy` and `s_vld` randomly toggled at 50%.
  - Required: payload and order identical to the input stream; `cmd_addr` and `cmd_len` held stable while `m_cmd_vld&!m_cmd_rdy`; `m_wdata` held stable while `m_wvld&!m_wrdy`.
- Zero-length transfer:
  - Stimulus: word_num=0.
  - Required: `done` in the cycle after start, `busy` stays 0, no `m_cmd_vld`, `s_rdy` stays 0.
- Start while busy:
  - Stimulus: second `cfg_start` with different base/num pulsed during DATA of an 18-word transfer.
  - Required: original transfer completes unchanged (2 commands, lengths 15 and 1); a single `done`.
- Reset mid-operation:
  - Stimulus: `arst_n` pulled low asynchronously mid-cycle during FILL at word 5.
  - Required: all outputs are 0 before the next edge; after release, a new 4-word start produces cmd (base, 3) and data 1..4.
- Address wrap:
  - Stimulus: base=0xFFFF_FFF8, stride=4, word_num=20, BURST=16.
  - Required: second command address is 0x0000_0038.
